// File: rtl/mem_pkg.sv
// Shared types and constants for the pipelined word memory.
package mem_pkg;

    typedef enum logic {INIT, RUN} state_t;

    localparam int MAX_READ_LATENCY = 4;
    localparam int BYTE_W           = 8;

    // Never returns less than 1 so a depth-1 array still gets a usable index.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Delay line for read results sitting behind the array read register.
// Only the valid bits are reset; data/err stages hold until a new result arrives.
module mem_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_err,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign out_err   = in_err;
        end else begin : g_stages
            logic [DEPTH-1:0]      valid_q;
            logic [DATA_WIDTH-1:0] data_q [DEPTH];
            logic [DEPTH-1:0]      err_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    valid_q <= '0;
                end else begin
                    valid_q[0] <= in_valid;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            // A stage only loads when the stage in front carries a result.
            always_ff @(posedge clk) begin
                if (in_valid) begin
                    data_q[0] <= in_data;
                    err_q[0]  <= in_err;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                        err_q[i]  <= err_q[i-1];
                    end
                end
            end

            assign out_valid = valid_q[DEPTH-1];
            assign out_data  = data_q[DEPTH-1];
            assign out_err   = err_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pipelined_memory.sv
// Byte-strobed word memory with independent write/read handshakes, a configurable
// read latency and a post-reset sweep that presets every word before traffic.
module pipelined_memory
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEM_DEPTH    = 1024,
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    READ_LATENCY = 2,
    parameter bit                    WRITE_FIRST  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_done,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [DATA_WIDTH/8-1:0]    wr_strb,
    input  logic                       rd_valid,
    output logic                       rd_ready,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic                       rd_data_valid,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_err
);

    localparam int IDX_W  = clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH / BYTE_W;
    localparam int LAT    = (READ_LATENCY < 1) ? 1 :
                            (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_ptr;

    logic                  wr_fire;
    logic                  rd_fire;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  collide;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  s0_valid;
    logic [DATA_WIDTH-1:0] s0_data;
    logic                  s0_err;
    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data;
    logic                  pipe_err;
    logic                  out_seen;

    assign wr_fire     = wr_valid & wr_ready;
    assign rd_fire     = rd_valid & rd_ready;
    assign wr_in_range = (32'(wr_addr) < MEM_DEPTH);
    assign rd_in_range = (32'(rd_addr) < MEM_DEPTH);
    assign collide     = wr_fire & rd_in_range & (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= INIT;
            init_ptr  <= '0;
            init_done <= 1'b0;
            wr_ready  <= 1'b0;
            rd_ready  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == LAST_ADDR) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                        wr_ready  <= 1'b1;
                        rd_ready  <= 1'b1;
                    end
                end
                RUN: begin
                end
            endcase
        end
    end

    // The sweep and user writes never overlap: wr_ready is low throughout INIT.
    always_ff @(posedge clk) begin
        if (rst && state == INIT) begin
            mem[init_ptr[IDX_W-1:0]] <= INIT_VALUE;
        end else if (wr_fire && wr_in_range) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr[IDX_W-1:0]][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Write-first forwarding merges the strobed bytes over the stored word.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr[IDX_W-1:0]];
            if (WRITE_FIRST && collide) begin
                for (int i = 0; i < STRB_W; i++) begin
                    if (wr_strb[i]) begin
                        rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
            s0_err   <= 1'b0;
        end else begin
            s0_valid <= rd_fire;
            if (rd_fire) begin
                s0_data <= rd_word;
                s0_err  <= ~rd_in_range;
            end
        end
    end

    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LAT - 1)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s0_valid),
        .in_data   (s0_data),
        .in_err    (s0_err),
        .out_valid (pipe_valid),
        .out_data  (pipe_data),
        .out_err   (pipe_err)
    );

    // Pipe data stages are not reset, so outputs read as zero until the first
    // result after reset has been delivered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_seen <= 1'b0;
        end else if (pipe_valid) begin
            out_seen <= 1'b1;
        end
    end

    assign rd_data_valid = pipe_valid;
    assign rd_data       = (out_seen | pipe_valid) ? pipe_data : '0;
    assign rd_err        = (out_seen | pipe_valid) ? pipe_err  : 1'b0;

endmodule

// File: tb/tb_pipelined_memory.sv
// Drives two differently configured memories with shared stimulus and checks
// each against a word-array reference model and a per-instance result queue.
module tb_pipelined_memory;

    localparam int          DEPTH_A = 1024;
    localparam int          DEPTH_B = 1000;
    localparam int          LAT_A   = 2;
    localparam int          LAT_B   = 3;
    localparam bit          WF_A    = 1'b1;
    localparam bit          WF_B    = 1'b0;
    localparam logic [31:0] INIT_A  = 32'h0000_0000;
    localparam logic [31:0] INIT_B  = 32'hC0DE_0001;

    typedef struct {
        longint      cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic        wv;
        logic [9:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        rv;
        logic [9:0]  ra;
        logic [31:0] ea;
        logic        erra;
        logic [31:0] eb;
        logic        errb;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_valid;
    logic [9:0]  rd_addr;

    logic        a_init_done, a_wr_ready, a_rd_ready, a_rd_data_valid, a_rd_err;
    logic [31:0] a_rd_data;
    logic        b_init_done, b_wr_ready, b_rd_ready, b_rd_data_valid, b_rd_err;
    logic [31:0] b_rd_data;

    logic [31:0] model [2][1024];
    exp_t        sb [2][$];
    logic [31:0] last_data [2];
    int          vectors = 0;
    int          miscompares = 0;
    longint      cyc = 0;
    int          rel = 0;
    bit          mon_en = 1'b0;
    vec_t        vecs [19];

    pipelined_memory #(
        .DATA_WIDTH(32), .MEM_DEPTH(DEPTH_A), .ADDR_WIDTH(10),
        .READ_LATENCY(LAT_A), .WRITE_FIRST(WF_A), .INIT_VALUE(INIT_A)
    ) dut_a (
        .clk(clk), .rst(rst), .init_done(a_init_done),
        .wr_valid(wr_valid), .wr_ready(a_wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(a_rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(a_rd_data_valid), .rd_data(a_rd_data), .rd_err(a_rd_err)
    );

    pipelined_memory #(
        .DATA_WIDTH(32), .MEM_DEPTH(DEPTH_B), .ADDR_WIDTH(10),
        .READ_LATENCY(LAT_B), .WRITE_FIRST(WF_B), .INIT_VALUE(INIT_B)
    ) dut_b (
        .clk(clk), .rst(rst), .init_done(b_init_done),
        .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(b_rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(b_rd_data_valid), .rd_data(b_rd_data), .rd_err(b_rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int depth_of(input int id);
        return (id == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    function automatic int lat_of(input int id);
        return (id == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from cycles since release.
    task automatic applyStimulus(input logic wv, input logic [9:0] wa, input logic [31:0] wd,
                                 input logic [3:0] ws, input logic rv, input logic [9:0] ra,
                                 input logic use_tab, input logic [31:0] ta, input logic tea,
                                 input logic [31:0] tb_d, input logic teb);
        exp_t e;
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_strb = ws;
        rd_valid = rv; rd_addr = ra;
        for (int id = 0; id < 2; id++) begin
            if (!rst) begin
                while (sb[id].size() > 0 && sb[id][$].cyc > cyc) void'(sb[id].pop_back());
                for (int k = 0; k < 1024; k++) model[id][k] = (id == 0) ? INIT_A : INIT_B;
            end else if (rel >= depth_of(id)) begin
                if (rv) begin
                    e.cyc = cyc + lat_of(id);
                    if (use_tab) begin
                        e.data = (id == 0) ? ta : tb_d;
                        e.err  = (id == 0) ? tea : teb;
                    end else if (int'(ra) >= depth_of(id)) begin
                        e.data = '0;
                        e.err  = 1'b1;
                    end else begin
                        e.data = model[id][ra];
                        if (((id == 0) ? WF_A : WF_B) && wv && wa == ra)
                            e.data = merge(e.data, wd, ws);
                        e.err = 1'b0;
                    end
                    sb[id].push_back(e);
                end
                if (wv && int'(wa) < depth_of(id)) model[id][wa] = merge(model[id][wa], wd, ws);
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            rel++;
        end else begin
            rel = 0;
            last_data[0] = '0;
            last_data[1] = '0;
        end
        check("dut0 rd_ready", 32'(a_rd_ready), 32'(rel >= DEPTH_A));
        check("dut0 wr_ready", 32'(a_wr_ready), 32'(rel >= DEPTH_A));
        check("dut0 init_done", 32'(a_init_done), 32'(rel >= DEPTH_A));
        check("dut1 rd_ready", 32'(b_rd_ready), 32'(rel >= DEPTH_B));
        check("dut1 wr_ready", 32'(b_wr_ready), 32'(rel >= DEPTH_B));
        check("dut1 init_done", 32'(b_init_done), 32'(rel >= DEPTH_B));
    endtask

    task automatic checkOutput(input int id);
        logic        v;
        logic [31:0] d;
        logic        e;
        logic        due;
        exp_t        x;
        v = (id == 0) ? a_rd_data_valid : b_rd_data_valid;
        d = (id == 0) ? a_rd_data : b_rd_data;
        e = (id == 0) ? a_rd_err : b_rd_err;
        due = (sb[id].size() > 0) && (sb[id][0].cyc == cyc);
        check($sformatf("dut%0d rd_data_valid", id), 32'(v), 32'(due));
        if (due) begin
            x = sb[id].pop_front();
            if (v) begin
                check($sformatf("dut%0d rd_data", id), d, x.data);
                check($sformatf("dut%0d rd_err", id), 32'(e), 32'(x.err));
            end
            last_data[id] = x.data;
        end else begin
            check($sformatf("dut%0d rd_data hold", id), d, last_data[id]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int id = 0; id < 2; id++) checkOutput(id);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 10'd0, 32'd0, 4'd0, 1'b0, 10'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic waitInit(input logic [9:0] ra);
        int low_cnt;
        low_cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            if (a_rd_ready) break;
            low_cnt++;
            applyStimulus(1'b0, 10'd0, 32'd0, 4'd0, 1'b1, ra, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        end
        check("dut0 cycles with rd_ready low after reset", 32'(low_cnt), 32'd1024);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 10'd3,    32'hDEADBEEF, 4'hF, 1'b0, 10'd0,    32'h0,        1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 10'd3,    32'h11223344, 4'h5, 1'b0, 10'd0,    32'h0,        1'b0, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 10'd3,    32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0};
        vecs[3]  = '{1'b1, 10'd0,    32'h0000000A, 4'hF, 1'b0, 10'd0,    32'h0,        1'b0, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 10'd1,    32'h0000000B, 4'hF, 1'b0, 10'd0,    32'h0,        1'b0, 32'h0,        1'b0};
        vecs[5]  = '{1'b1, 10'd2,    32'h0000000C, 4'hF, 1'b0, 10'd0,    32'h0,        1'b0, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 10'd0,    32'h0000000A, 1'b0, 32'h0000000A, 1'b0};
        vecs[7]  = '{1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 10'd1,    32'h0000000B, 1'b0, 32'h0000000B, 1'b0};
        vecs[8]  = '{1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 10'd2,    32'h0000000C, 1'b0, 32'h0000000C, 1'b0};
        vecs[9]  = '{1'b1, 10'd7,    32'h12345678, 4'hF, 1'b1, 10'd7,    32'h12345678, 1'b0, INIT_B,       1'b0};
        vecs[10] = '{1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 10'd7,    32'h12345678, 1'b0, 32'h12345678, 1'b0};
        vecs[11] = '{1'b1, 10'd1000, 32'hFFFFFFFF, 4'hF, 1'b0, 10'd0,    32'h0,        1'b0, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 10'd1000, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 10'd999,  32'h0,        1'b0, INIT_B,       1'b0};
        vecs[14] = '{1'b1, 10'd20,   32'hAABBCCDD, 4'h0, 1'b1, 10'd20,   32'h0,        1'b0, INIT_B,       1'b0};
        vecs[15] = '{1'b1, 10'd1023, 32'h12345655, 4'h1, 1'b1, 10'd1023, 32'h00000055, 1'b0, 32'h0,        1'b1};
        vecs[16] = '{1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 10'd1023, 32'h00000055, 1'b0, 32'h0,        1'b1};
        vecs[17] = '{1'b1, 10'd3,    32'hFFFFFFFF, 4'h8, 1'b1, 10'd3,    32'hFF22BE44, 1'b0, 32'hDE22BE44, 1'b0};
        vecs[18] = '{1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 10'd3,    32'hFF22BE44, 1'b0, 32'hFF22BE44, 1'b0};

        rst = 1'b0;
        idle(1);
        mon_en = 1'b1;

        rst = 1'b1;
        waitInit(10'd5);
        applyStimulus(1'b0, 10'd0, 32'd0, 4'd0, 1'b1, 10'd5, 1'b1, 32'h0, 1'b0, INIT_B, 1'b0);
        idle(5);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].ws, vecs[i].rv, vecs[i].ra,
                          1'b1, vecs[i].ea, vecs[i].erra, vecs[i].eb, vecs[i].errb);
        end
        idle(5);

        // Small address pool forces frequent collisions; the top range hits dut1's hole.
        for (int i = 0; i < 400; i++) begin
            logic [9:0] wa;
            logic [9:0] ra;
            wa = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(990, 1023));
            ra = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(990, 1023));
            if ($urandom_range(0, 3) == 0) ra = wa;
            applyStimulus(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), ra, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        end
        idle(5);

        applyStimulus(1'b1, 10'd3, 32'h5555AAAA, 4'hF, 1'b0, 10'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 10'd0, 32'd0, 4'd0, 1'b1, 10'd3, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 10'd0, 32'd0, 4'd0, 1'b1, 10'd3, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        waitInit(10'd3);
        applyStimulus(1'b0, 10'd0, 32'd0, 4'd0, 1'b1, 10'd3, 1'b1, INIT_A, 1'b0, INIT_B, 1'b0);
        applyStimulus(1'b0, 10'd0, 32'd0, 4'd0, 1'b1, 10'd7, 1'b1, INIT_A, 1'b0, INIT_B, 1'b0);
        applyStimulus(1'b0, 10'd0, 32'd0, 4'd0, 1'b1, 10'd1000, 1'b1, INIT_A, 1'b0, 32'h0, 1'b1);
        idle(6);

        check("dut0 outstanding reads", 32'(sb[0].size()), 32'd0);
        check("dut1 outstanding reads", 32'(sb[1].size()), 32'd0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipelined_memory.md
Name: pipelined_memory

Overview:
Parametrised successor of the single-port word memory. It has:
- an independent write port with per-byte strobes and a read port, both using valid/ready handshakes;
- configurable read latency and read/write collision mode;
- a post-reset clear sweep that zeroes (or presets) the whole array before accepting traffic.

It sits behind the AXI4 controller as its backing store.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8.
MEM_DEPTH, 1024, number of words; need not be a power of two.
ADDR_WIDTH, 10, word address width; must satisfy 2**ADDR_WIDTH >= MEM_DEPTH.
READ_LATENCY, 2, cycles from accepted read to rd_data_valid; legal range 1..4.
WRITE_FIRST, 1, 1 = same-cycle same-address read returns new data; 0 = returns old data.
INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during the init sweep.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
init_done  out  1  high once the init sweep completes
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_addr  in  ADDR_WIDTH  word address
wr_data  in  DATA_WIDTH  write data
wr_strb  in  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i]
rd_valid  in  1  read request
rd_ready  out  1  read accepted when rd_valid & rd_ready
rd_addr  in  ADDR_WIDTH  word address
rd_data_valid  out  1  single-cycle pulse marking rd_data valid
rd_data  out  DATA_WIDTH  read data
rd_err  out  1  qualified by rd_data_valid; read address was >= MEM_DEPTH

Behaviour:
- Reset (rst=0 at an edge): init_done=0, wr_ready=0, rd_ready=0, rd_data_valid=0, rd_data=0, rd_err=0. All read-pipeline valid stages are cleared. The FSM enters INIT with init_ptr=0. Array contents are not reset directly.
- FSM states: INIT, RUN.
- INIT:
  - Writes INIT_VALUE to mem[init_ptr] each cycle, then increments init_ptr.
  - On the cycle init_ptr == MEM_DEPTH-1 is written, moves to RUN.
  - init_done, wr_ready and rd_ready go high on the first RUN cycle, i.e. MEM_DEPTH cycles after rst is released.
  - Requests presented during INIT are not accepted.
- RUN:
  - wr_ready = rd_ready = 1 every cycle. There is no backpressure.
  - RUN is left only via reset.
- Write: on an accepted write, each byte with wr_strb[i]=1 is updated at the edge. Bytes with strobe 0 keep their old value. wr_strb=0 is a legal no-op. If wr_addr >= MEM_DEPTH, the write is dropped silently.
- Read:
  - Accepted at edge T. rd_data_valid=1 and rd_data are presented for exactly the cycle following edge T+READ_LATENCY-1, so latency 1 means valid right after the next edge.
  - Fully pipelined: one read per cycle, back-to-back reads return in order, one result per cycle.
  - rd_data holds its last value while rd_data_valid=0.
- Out-of-range read (rd_addr >= MEM_DEPTH): returns rd_data=0 and rd_err=1 with the normal latency. rd_err=0 for all in-range reads.
- Collision (write and read accepted in the same cycle, same in-range address):
  - WRITE_FIRST=1: the read returns the byte-merged new word (strobed bytes new, others old).
  - WRITE_FIRST=0: the read returns the pre-write word.
  - Different addresses: no interaction.
- Reads issued after a write's edge always see that write.
- Reset mid-operation: in-flight reads are discarded and no rd_data_valid is emitted. The init sweep reruns in full.

Decomposition:
- Package mem_pkg holds:
  - state enum {INIT, RUN};
  - clog2 function;
  - constants MAX_READ_LATENCY=4 and BYTE_W=8.
- One sub-module, mem_rd_pipe: a valid/data/err delay line of depth READ_LATENCY-1 behind the array read register. It has its own synchronous active-low reset on the valid bits only.

Test Plan:
1. Release rst, hold rd_valid=1 at addr 5 throughout -> rd_ready=0 for exactly 1024 cycles; first accepted read returns 0x00000000 at latency 2; init_done rises on cycle 1024.
2. Write 0xDEADBEEF to addr 3 with strb=0xF, then write 0x11223344 with strb=0x5, then read addr 3 -> 0xDE22BE44 after 2 cycles.
3. Back-to-back reads of addrs 0,1,2 after writing 0xA,0xB,0xC -> three consecutive rd_data_valid cycles carrying 0xA,0xB,0xC.
4. Same-cycle write 0x12345678 (strb=0xF) and read of addr 7, which holds 0x0 -> returns 0x12345678 with WRITE_FIRST=1 and 0x00000000 with WRITE_FIRST=0.
5. MEM_DEPTH=1000: write 0xFFFFFFFF to addr 1000, then read addr 1000 -> rd_data=0, rd_err=1; addr 999 unchanged.
6. Issue 2 reads, assert rst=0 for 1 cycle on the next edge -> no rd_data_valid pulses; rd_ready low for a further 1024 cycles; previously written data reads back as INIT_VALUE.
